// File: rtl/counter_load_arbiter_if.sv
// counter_load_arbiter_if
//   Bundles the requester/counter-facing signals of counter_load_arbiter.
//   master : requester side (drives req/req_data, observes grant and load)
//   slave  : arbiter side (samples req/req_data, drives grant and load)
//   Signals: req[NUM_REQ], req_data[4*NUM_REQ], gnt[NUM_REQ], load,
//            load_data[4], busy, last_gnt_id[ID_W]
interface counter_load_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic                 load;
  logic [3:0]           load_data;
  logic                 busy;
  logic [ID_W-1:0]      last_gnt_id;

  modport master (
    output req, req_data,
    input  gnt, load, load_data, busy, last_gnt_id
  );

  modport slave (
    input  req, req_data,
    output gnt, load, load_data, busy, last_gnt_id
  );
endinterface

// File: rtl/counter_load_arbiter.sv
// counter_load_arbiter
//   Round-robin arbiter sharing the synchronous load port of a 4-bit
//   loadable counter among NUM_REQ requesters. A grant drives load/load_data
//   for one cycle, then HOLDOFF cycles of free counting follow before the
//   next grant.
//   Ports:
//     clk      - single clock, rising edge
//     reset_n  - asynchronous active-low reset
//     bus      - counter_load_arbiter_if.slave (req, req_data, gnt, load,
//                load_data, busy, last_gnt_id)
//     load_cnt - 8-bit saturating count of LOAD cycles, present only when
//                COUNTER_ARB_STATS_EN is defined
//
//   state | meaning
//   IDLE  | sample req, grant the first requester at/after the pointer
//   LOAD  | gnt/load high for exactly this cycle
//   HOLD  | hold-off window, requests ignored until hold_cnt reaches 0
module counter_load_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int HOLDOFF = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  counter_load_arbiter_if.slave   bus
`ifdef COUNTER_ARB_STATS_EN
  ,
  output logic [7:0]              load_cnt
`endif
);

  localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] HOLD_INIT = (HOLDOFF > 0) ? 4'(HOLDOFF - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [3:0]         hold_cnt;

  logic [NUM_REQ-1:0] hi_req;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [NUM_REQ-1:0] pick_oh;
  logic [3:0]         pick_data;

  // Requests at or above the pointer win first; otherwise wrap to the
  // lowest set index. Descending loops leave the lowest match in place.
  always_comb begin
    hi_req     = '0;
    pick_valid = |bus.req;
    pick_id    = '0;
    pick_oh    = '0;
    pick_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = bus.req[i] & (ID_W'(i) >= ptr);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        pick_id    = ID_W'(i);
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
        pick_data  = bus.req_data[4*i +: 4];
      end
    end
    if (|hi_req) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (hi_req[i]) begin
          pick_id    = ID_W'(i);
          pick_oh    = '0;
          pick_oh[i] = 1'b1;
          pick_data  = bus.req_data[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      hold_cnt        <= '0;
      bus.gnt         <= '0;
      bus.load        <= 1'b0;
      bus.load_data   <= '0;
      bus.last_gnt_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            bus.gnt         <= pick_oh;
            bus.load        <= 1'b1;
            bus.load_data   <= pick_data;
            bus.last_gnt_id <= pick_id;
            ptr             <= (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
            state           <= LOAD;
          end
        end
        LOAD: begin
          bus.gnt  <= '0;
          bus.load <= 1'b0;
          if (HOLDOFF == 0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= HOLD_INIT;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.load <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = (state != IDLE);

`ifdef COUNTER_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt <= '0;
    end else if (state == LOAD && load_cnt != 8'hFF) begin
      load_cnt <= load_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_load_arbiter.sv
// tb_counter_load_arbiter
//   Directed bench for counter_load_arbiter. dut_a uses NUM_REQ=4/HOLDOFF=2
//   and feeds a small 4-bit loadable counter model; dut_b uses HOLDOFF=0.
//   Optional load_cnt ports are exercised when COUNTER_ARB_STATS_EN is defined.
module tb_counter_load_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  counter_load_arbiter_if #(.NUM_REQ(4)) bus_a ();
  counter_load_arbiter_if #(.NUM_REQ(4)) bus_b ();

`ifdef COUNTER_ARB_STATS_EN
  logic [7:0] load_cnt_a;
  logic [7:0] load_cnt_b;
`endif

  counter_load_arbiter #(.NUM_REQ(4), .HOLDOFF(2)) dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_a)
`ifdef COUNTER_ARB_STATS_EN
    ,
    .load_cnt (load_cnt_a)
`endif
  );

  counter_load_arbiter #(.NUM_REQ(4), .HOLDOFF(0)) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_b)
`ifdef COUNTER_ARB_STATS_EN
    ,
    .load_cnt (load_cnt_b)
`endif
  );

  // counter sitting behind dut_a
  logic [3:0] cnt_a;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_a <= '0;
    else if (bus_a.load) cnt_a <= bus_a.load_data;
    else cnt_a <= cnt_a + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.req      = '0;
    bus_a.req_data = 16'h7A53;
    bus_b.req      = '0;
    bus_b.req_data = 16'h0091;

    // reset values
    #1;
    chk("rst_gnt", bus_a.gnt, 0);
    chk("rst_load", bus_a.load, 0);
    chk("rst_ldata", bus_a.load_data, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_last", bus_a.last_gnt_id, 0);
    step();
    step();
    #3 reset_n = 1'b1;

    // single request from requester 2
    bus_a.req = 4'b0100;
    step();
    chk("single_gnt", bus_a.gnt, 4'b0100);
    chk("single_load", bus_a.load, 1);
    chk("single_ldata", bus_a.load_data, 4'hA);
    chk("single_last", bus_a.last_gnt_id, 2);
    chk("single_busy0", bus_a.busy, 1);
    bus_a.req = '0;
    step();
    chk("single_load_clr", bus_a.load, 0);
    chk("single_gnt_clr", bus_a.gnt, 0);
    chk("single_busy1", bus_a.busy, 1);
    chk("single_cnt0", cnt_a, 4'hA);
    step();
    chk("single_busy2", bus_a.busy, 1);
    chk("single_cnt1", cnt_a, 4'hB);
    step();
    chk("single_busy3", bus_a.busy, 0);
    chk("single_ldata_hold", bus_a.load_data, 4'hA);
    chk("single_last_hold", bus_a.last_gnt_id, 2);

    // reset in the middle of a LOAD cycle (pointer is 3 here)
    bus_a.req = 4'b1000;
    step();
    chk("midload_gnt", bus_a.gnt, 4'b1000);
    bus_a.req = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("midload_rst_load", bus_a.load, 0);
    chk("midload_rst_gnt", bus_a.gnt, 0);
    chk("midload_rst_busy", bus_a.busy, 0);
    chk("midload_rst_last", bus_a.last_gnt_id, 0);
    #2 reset_n = 1'b1;

    // all requesting: 0,1,2,3,0 spaced 4 cycles
    bus_a.req = 4'b1111;
    step();
    chk("rr_first", bus_a.gnt, 4'b0001);
    for (int g = 1; g <= 4; g++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        chk("rr_gap", bus_a.gnt, 0);
      end
      step();
      chk("rr_gnt", bus_a.gnt, 32'(1) << (g % 4));
      chk("rr_onehot", 32'($onehot0(bus_a.gnt)), 1);
      chk("rr_last", bus_a.last_gnt_id, g % 4);
    end
    bus_a.req = '0;
    for (int c = 0; c < 3; c++) step();
    chk("rr_idle", bus_a.busy, 0);

    // request raised during HOLD waits for IDLE (pointer is 1, wraps to 0)
    bus_a.req = 4'b0001;
    step();
    chk("hold_wrap_gnt", bus_a.gnt, 4'b0001);
    bus_a.req = '0;
    step();
    bus_a.req = 4'b0100;
    step();
    chk("hold_ignore0", bus_a.gnt, 0);
    step();
    chk("hold_ignore1", bus_a.gnt, 0);
    step();
    chk("hold_grant", bus_a.gnt, 4'b0100);
    chk("hold_grant_data", bus_a.load_data, 4'hA);
    bus_a.req = '0;

    // request dropped during HOLD is lost
    step();
    bus_a.req = 4'b1000;
    step();
    bus_a.req = '0;
    step();
    step();
    chk("drop_gnt0", bus_a.gnt, 0);
    step();
    chk("drop_gnt1", bus_a.gnt, 0);
    chk("drop_busy", bus_a.busy, 0);
    chk("drop_last", bus_a.last_gnt_id, 2);

    // HOLDOFF=0 back-to-back alternation
    bus_b.req = 4'b0011;
    step();
    chk("b2b_g0", bus_b.gnt, 4'b0001);
    chk("b2b_d0", bus_b.load_data, 4'h1);
    step();
    chk("b2b_gap0", bus_b.gnt, 0);
    chk("b2b_busy_gap", bus_b.busy, 0);
    step();
    chk("b2b_g1", bus_b.gnt, 4'b0010);
    chk("b2b_d1", bus_b.load_data, 4'h9);
    step();
    chk("b2b_gap1", bus_b.load, 0);
    step();
    chk("b2b_g2", bus_b.gnt, 4'b0001);

`ifdef COUNTER_ARB_STATS_EN
    // three loads so far on dut_b; keep going well past saturation
    for (int c = 0; c < 620; c++) step();
    chk("stats_sat", load_cnt_b, 8'hFF);
    bus_b.req = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("stats_rst_b", load_cnt_b, 0);
    chk("stats_rst_a", load_cnt_a, 0);
    #2 reset_n = 1'b1;
`endif

    bus_b.req = '0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
